// File: rtl/peak_rv32im_pkg.sv
// rtl/peak_rv32im_pkg.sv - shared types and constants for the rv32im fetch stage
//
// Purpose:
//   Types and constants used by the fetch stage and its queues.
//   - NOP_INST      : canonical RV32I NOP (addi x0, x0, 0). Fetch presents it
//                     when no real instruction is available or the fetch faulted.
//   - fetch_entry_t : one decode-bound entry {fault, pc, inst}.
//   - word_align()  : clears the byte-offset bits of an address.
package peak_rv32im_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/peak_sync_fifo.sv
// rtl/peak_sync_fifo.sv - synchronous FIFO with flush, generic entry type
//
// Purpose:
//   Small circular-buffer FIFO. The head entry comes straight from storage, so
//   a word pushed on one edge is visible at the head from the next cycle.
//   Flush takes priority over push and pop.
// Parameters:
//   DEPTH  number of entries (power of 2, >= 2)
//   T      entry type
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   flush      in   empty the FIFO (wins over push/pop)
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   drop the head entry (ignored when empty)
//   head       out  oldest entry (meaningless when count == 0)
//   count      out  number of valid entries, 0..DEPTH
module peak_sync_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           full;
  logic           empty;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset; count gates every use of the head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // Users size their credit so that a push never meets a full FIFO.
  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));

endmodule

// File: rtl/peak_rv32im_fetch.sv
// rtl/peak_rv32im_fetch.sv - rv32im instruction fetch stage
//
// Purpose:
//   Issues sequential word fetches on a req/gnt/rvalid instruction-memory port,
//   buffers returned words with their PCs and hands them to decode over a
//   valid/ready handshake. Handles redirects (flush + restart) and fetch faults
//   (fault entry, then issue halts until the next redirect).
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  output queue depth and in-flight credit (power of 2, >= 2)
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   REDIRECT, REDIRECT_PC     restart fetch at REDIRECT_PC (word aligned)
//   I_MEM_REQ, I_MEM_ADDR     fetch request and word address
//   I_MEM_GNT                 request accepted when REQ && GNT
//   I_MEM_RVALID, I_MEM_RDATA, I_MEM_ERR   in-order response, bus error
//   INST_VALID, INST_CODE, INST_PC, INST_FAULT   entry to decode
//   INST_READY                decode consumes the entry when VALID && READY
module peak_rv32im_fetch
  import peak_rv32im_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        I_MEM_REQ,
  output logic [31:0] I_MEM_ADDR,
  input  logic        I_MEM_GNT,
  input  logic        I_MEM_RVALID,
  input  logic [31:0] I_MEM_RDATA,
  input  logic        I_MEM_ERR,
  output logic        INST_VALID,
  output logic [31:0] INST_CODE,
  output logic [31:0] INST_PC,
  output logic        INST_FAULT,
  input  logic        INST_READY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          running;
  logic          req_hold;
  logic          halted;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit_used;
  logic          credit_ok;
  logic          accept;
  logic          rsp_live;
  logic          rsp_drop;
  logic          inst_valid;
  logic          pop;
  logic [31:0]   inflight_pc;
  fetch_entry_t  q_in;
  fetch_entry_t  q_head;

  // Stale responses still owed after a redirect occupy credit too, so a new
  // stream can never have more requests in flight than the queue can absorb.
  assign credit_used = {1'b0, q_count} + {1'b0, outstanding} + {1'b0, drop_cnt};
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

  // running keeps REQ low while RST is held; req_hold keeps an ungranted
  // request (and its address) up even if a fault halts issue meanwhile.
  assign I_MEM_REQ  = running && (req_hold || (credit_ok && !halted));
  assign I_MEM_ADDR = pc;
  assign accept     = I_MEM_REQ && I_MEM_GNT;

  // A response in the redirect cycle is always stale.
  assign rsp_live = I_MEM_RVALID && !REDIRECT && (drop_cnt == '0);
  assign rsp_drop = I_MEM_RVALID && !REDIRECT && (drop_cnt != '0);

  assign inst_valid = (q_count != '0);
  assign pop        = inst_valid && INST_READY && !REDIRECT;

  always_comb begin
    q_in       = '0;
    q_in.fault = I_MEM_ERR;
    q_in.pc    = inflight_pc;
    q_in.inst  = I_MEM_ERR ? NOP_INST : I_MEM_RDATA;
  end

  // PCs of accepted requests, in request order; its count is the outstanding counter.
  peak_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [31:0])
  ) u_inflight (
    .clk       (CLK),
    .rst       (RST),
    .flush     (REDIRECT),
    .push      (accept && !REDIRECT),
    .push_data (pc),
    .pop       (rsp_live),
    .head      (inflight_pc),
    .count     (outstanding)
  );

  peak_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .clk       (CLK),
    .rst       (RST),
    .flush     (REDIRECT),
    .push      (rsp_live),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      running  <= 1'b0;
      req_hold <= 1'b0;
      halted   <= 1'b0;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      running <= 1'b1;
      if (REDIRECT) begin
        pc       <= word_align(REDIRECT_PC);
        req_hold <= 1'b0;
        halted   <= 1'b0;
        // Everything in flight becomes stale, including a request accepted
        // this cycle; a response arriving this cycle already retires one.
        drop_cnt <= drop_cnt + outstanding + CW'(accept) - CW'(I_MEM_RVALID);
      end else begin
        if (accept) pc <= pc + 32'd4;
        req_hold <= I_MEM_REQ && !I_MEM_GNT;
        if (rsp_live && I_MEM_ERR) halted <= 1'b1;
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  assign INST_VALID = inst_valid;
  assign INST_CODE  = inst_valid ? q_head.inst : NOP_INST;
  assign INST_PC    = inst_valid ? q_head.pc : RESET_PC;
  assign INST_FAULT = inst_valid && q_head.fault;

endmodule

// File: tb/tb_peak_rv32im_fetch.sv
// tb/tb_peak_rv32im_fetch.sv - scoreboard testbench for peak_rv32im_fetch
module tb_peak_rv32im_fetch;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        I_MEM_REQ;
  logic [31:0] I_MEM_ADDR;
  logic        I_MEM_GNT = 1'b0;
  logic        I_MEM_RVALID = 1'b0;
  logic [31:0] I_MEM_RDATA = '0;
  logic        I_MEM_ERR = 1'b0;
  logic        INST_VALID;
  logic [31:0] INST_CODE;
  logic [31:0] INST_PC;
  logic        INST_FAULT;
  logic        INST_READY = 1'b0;

  always #5 CLK = ~CLK;

  peak_rv32im_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .I_MEM_REQ(I_MEM_REQ), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_GNT(I_MEM_GNT),
    .I_MEM_RVALID(I_MEM_RVALID), .I_MEM_RDATA(I_MEM_RDATA), .I_MEM_ERR(I_MEM_ERR),
    .INST_VALID(INST_VALID), .INST_CODE(INST_CODE), .INST_PC(INST_PC),
    .INST_FAULT(INST_FAULT), .INST_READY(INST_READY)
  );

  typedef struct { logic [31:0] pc; logic [31:0] code; logic fault; } exp_t;
  typedef struct { logic [31:0] addr; logic err; int gen; int due; } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gen = 0;
  int last_due = 0;
  int faults_seen = 0;
  int delivered = 0;

  bit gnt_low = 0, gnt_rand = 0, ready_low = 0, ready_rand = 0;
  int lat_min = 1, lat_max = 1;
  bit err_armed = 0;
  logic [31:0] err_addr = '0;

  logic [31:0] model_pc = RESET_PC;
  bit model_halted = 0, prev_pending = 0, after_redirect = 0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive inputs at negedge, act as memory, update the model.
  // mode 0: no redirect, 1: redirect, 2: redirect only if REQ and a response coincide.
  task automatic cycle(input int mode, input logic [31:0] rpc, output bit did);
    mem_t rsp;
    bit rsp_v, redir, is_err;
    int lat, due;
    @(negedge CLK);
    rsp_v = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    redir = (mode == 1) || (mode == 2 && I_MEM_REQ && rsp_v);
    did = redir;
    I_MEM_GNT  = (mode == 2 && redir) ? 1'b1 : gnt_low ? 1'b0 :
                 gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    INST_READY = ready_low ? 1'b0 : ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    REDIRECT = redir;
    REDIRECT_PC = rpc;
    if (rsp_v) begin
      rsp = mem_q.pop_front();
      I_MEM_RVALID = 1'b1;
      I_MEM_RDATA  = rsp.addr ^ DATA_KEY;
      I_MEM_ERR    = rsp.err;
    end else begin
      I_MEM_RVALID = 1'b0;
      I_MEM_RDATA  = $urandom;
      I_MEM_ERR    = 1'($urandom_range(0, 1));
    end
    #1;
    if (prev_pending) begin
      chk("req_held", I_MEM_REQ, 1);
      chk("addr_held", I_MEM_ADDR, prev_addr);
    end
    if (after_redirect) chk("addr_after_redirect", I_MEM_ADDR, model_pc);
    if (model_halted && !prev_pending) chk("no_req_when_halted", I_MEM_REQ, 0);
    if (I_MEM_REQ && I_MEM_GNT) begin
      lat = $urandom_range(lat_min, lat_max);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: I_MEM_ADDR, err: err_armed && (I_MEM_ADDR == err_addr),
                        gen: gen, due: due});
      if (!redir) begin
        chk("fetch_addr", I_MEM_ADDR, model_pc);
        is_err = err_armed && (model_pc == err_addr);
        exp_q.push_back('{pc: model_pc, code: is_err ? NOP : (model_pc ^ DATA_KEY), fault: is_err});
        model_pc = model_pc + 32'd4;
      end
    end
    if (rsp_v && rsp.gen == gen && !redir && rsp.err) model_halted = 1;
    prev_pending = I_MEM_REQ && !I_MEM_GNT && !redir;
    prev_addr = I_MEM_ADDR;
    after_redirect = redir;
    if (redir) begin
      exp_q.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
      gen++;
      model_halted = 0;
    end
    cyc++;
  endtask

  // Monitor: compares every consumed entry against the scoreboard.
  bit   prev_redir_m = 0, hold_m = 0;
  exp_t held, e;
  always @(negedge CLK) begin
    #2;
    if (!RST) begin
      if (prev_redir_m) chk("valid_after_redirect", INST_VALID, 0);
      if (hold_m) begin
        chk("hold_valid", INST_VALID, 1);
        chk("hold_pc", INST_PC, held.pc);
        chk("hold_code", INST_CODE, held.code);
        chk("hold_fault", INST_FAULT, held.fault);
      end
      if (INST_VALID && INST_READY && !REDIRECT) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_inst: got pc %h expected no entry", INST_PC);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", INST_PC, e.pc);
          chk("inst_code", INST_CODE, e.code);
          chk("inst_fault", INST_FAULT, e.fault);
          delivered++;
          if (INST_FAULT) faults_seen++;
        end
      end
      prev_redir_m = REDIRECT;
      hold_m = INST_VALID && !INST_READY && !REDIRECT;
      held = '{pc: INST_PC, code: INST_CODE, fault: INST_FAULT};
    end
  end

  initial begin
    bit did;
    int n;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", I_MEM_REQ, 0);
    chk("rst_addr", I_MEM_ADDR, RESET_PC);
    chk("rst_valid", INST_VALID, 0);
    chk("rst_code", INST_CODE, NOP);
    chk("rst_pc", INST_PC, RESET_PC);
    chk("rst_fault", INST_FAULT, 0);
    @(negedge CLK);
    RST = 1'b0;

    // 1: streaming, 1-cycle memory, decode always ready
    repeat (20) cycle(0, '0, did);

    // 2: decode stalls; fetch must stop once the queue is full
    ready_low = 1;
    repeat (10) cycle(0, '0, did);
    #1;
    chk("req_dropped_when_full", I_MEM_REQ, 0);
    chk("valid_while_stalled", INST_VALID, 1);
    ready_low = 0;
    repeat (10) cycle(0, '0, did);

    // 3: redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    n = 0;
    while (mem_q.size() < 2 && n < 20) begin
      cycle(0, '0, did);
      n++;
    end
    chk("two_outstanding", mem_q.size(), 2);
    cycle(1, 32'h0000_0102, did);
    lat_min = 1; lat_max = 1;
    repeat (20) cycle(0, '0, did);

    // 4: bus error on the word at 0x8, then halt until redirect to 0x40
    cycle(1, 32'h0000_0000, did);
    err_armed = 1; err_addr = 32'h8;
    gnt_rand = 1; ready_rand = 1; lat_min = 1; lat_max = 3;
    faults_seen = 0;
    repeat (40) cycle(0, '0, did);
    chk("fault_entries", faults_seen, 1);
    cycle(1, 32'h0000_0040, did);
    err_armed = 0;
    repeat (20) cycle(0, '0, did);

    // 5: grant withheld; address must stay put, redirect mid-stall
    gnt_rand = 0; ready_rand = 0; lat_min = 1; lat_max = 2;
    gnt_low = 1;
    repeat (3) cycle(0, '0, did);
    cycle(1, 32'h0000_0200, did);
    repeat (2) cycle(0, '0, did);
    gnt_low = 0;
    repeat (15) cycle(0, '0, did);

    // 6: PC wrap, and redirect coinciding with a response and a grant
    lat_min = 2; lat_max = 2;
    cycle(1, 32'hFFFF_FFF8, did);
    repeat (10) cycle(0, '0, did);
    did = 0;
    n = 0;
    while (!did && n < 40) begin
      cycle(2, 32'hFFFF_FFFC, did);
      n++;
    end
    chk("coincident_redirect_done", did, 1);
    repeat (20) cycle(0, '0, did);

    // Random soak with occasional redirects
    gnt_rand = 1; ready_rand = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) cycle(1, $urandom, did);
      else cycle(0, '0, did);
    end
    ready_rand = 0;
    repeat (20) cycle(0, '0, did);
    tests++;
    if (delivered < 50) begin
      fails++;
      $display("FAIL delivered_count: got %0d expected at least 50", delivered);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
